ccd_frame_writer: RTL

Capture-to-memory DMA writer for the CCD path: accepts 14-bit AFE pixels already synchronized into the system clock, packs four pixels per 64-bit word, buffers them in a FIFO and writes one frame to memory over an AXI write-only master port. It is the write-side counterpart of the display controller's AXI frame reader and sits between the CCD capture front end and the system AXI interconnect. Control is a start/busy/done handshake driven by a register block.

---
 rtl/ccd_frame_writer_if.sv | 41 ++++
 rtl/ccd_frame_writer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ccd_frame_writer_if.sv
// rtl/ccd_frame_writer_if.sv - AXI write-only channel bundle for the CCD frame writer
interface ccd_frame_writer_if #(
    parameter int AXI_AW  = 32,
    parameter int AXI_DW  = 64,
    parameter int AXI_IDW = 1
);
    logic [AXI_AW-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [AXI_IDW-1:0]  awid;
    logic                awvalid;
    logic                awready;
    logic [AXI_DW-1:0]   wdata;
    logic [AXI_DW/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic [AXI_IDW-1:0]  bid;
    logic                bvalid;
    logic                bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awid, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bid, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awid, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bid, bvalid,
        input  bready
    );
endinterface

// File: rtl/ccd_frame_writer.sv
// rtl/ccd_frame_writer.sv - CCD pixel packer, word FIFO and AXI burst writer for one frame
module ccd_frame_writer #(
    parameter int AXI_AW     = 32,
    parameter int AXI_DW     = 64,
    parameter int AXI_IDW    = 1,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AXI_AW-1:0] cfg_base,
    input  logic [23:0]       cfg_pixels,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              err,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [13:0]       pix_data,
    ccd_frame_writer_if.master m
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(BURST_LEN) + 1;
    localparam logic [PW:0] FULL_CNT  = FIFO_DEPTH[PW:0];
    localparam logic [PW:0] BURST_CNT = BURST_LEN[PW:0];

    typedef enum logic [1:0] {C_IDLE, C_ARM, C_RUN} cap_state_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_t;

    cap_state_t          c_state;
    wr_state_t           w_state;
    logic [AXI_AW-1:0]   base;
    logic [21:0]         frame_words;
    logic [21:0]         words_pushed;
    logic [21:0]         words_sent;
    logic [1:0]          pack_idx;
    logic [47:0]         pack;
    logic                capture_end;
    logic [AXI_DW-1:0]   mem [FIFO_DEPTH];
    logic [PW:0]         wr_ptr;
    logic [PW:0]         rd_ptr;
    logic [PW:0]         fifo_count;
    logic                fifo_full;
    logic                push;
    logic                pop;
    logic [AXI_DW-1:0]   push_word;
    logic [LW-1:0]       len;
    logic [LW-1:0]       beat;
    logic [LW-1:0]       issue_len;
    logic                unused_inputs;

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_count == FULL_CNT);
    assign push_word  = {2'b00, pix_data, pack};
    assign push       = (c_state == C_RUN) && pix_valid && (pack_idx == 2'd3) && !fifo_full;
    assign pop        = (w_state == W_DATA) && m.wvalid && m.wready;
    // A short tail burst only happens once capture has ended, so fifo_count fits in len then.
    assign issue_len  = (fifo_count >= BURST_CNT) ? BURST_LEN[LW-1:0] : fifo_count[LW-1:0];

    assign m.awsize   = 3'd3;
    assign m.awburst  = 2'b01;
    assign m.awid     = '0;
    assign m.wstrb    = '1;
    assign m.wdata    = m.wvalid ? mem[rd_ptr[PW-1:0]] : '0;

    assign unused_inputs = ^{m.bid, cfg_pixels[1:0]};

    // FIFO storage: written on every accepted push, read combinationally at the head.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= push_word;
    end

    // Capture FSM, write FSM and FIFO pointers share one block since busy/capture_end cross both.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_state      <= C_IDLE;
            w_state      <= W_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            err          <= 1'b0;
            base         <= '0;
            frame_words  <= '0;
            words_pushed <= '0;
            words_sent   <= '0;
            pack_idx     <= 2'd0;
            pack         <= '0;
            capture_end  <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            len          <= '0;
            beat         <= '0;
            m.awaddr     <= '0;
            m.awlen      <= '0;
            m.awvalid    <= 1'b0;
            m.wvalid     <= 1'b0;
            m.wlast      <= 1'b0;
            m.bready     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case (c_state)
                C_IDLE: begin
                    if (start && !busy) begin
                        base         <= cfg_base;
                        frame_words  <= cfg_pixels[23:2];
                        words_pushed <= '0;
                        words_sent   <= '0;
                        overflow     <= 1'b0;
                        err          <= 1'b0;
                        capture_end  <= 1'b0;
                        pack_idx     <= 2'd0;
                        busy         <= 1'b1;
                        c_state      <= C_ARM;
                    end
                end
                C_ARM: begin
                    if (pix_valid && pix_sof) begin
                        pack[15:0] <= {2'b00, pix_data};
                        pack_idx   <= 2'd1;
                        c_state    <= C_RUN;
                    end
                end
                C_RUN: begin
                    if (pix_valid) begin
                        if (pack_idx == 2'd3) begin
                            pack_idx <= 2'd0;
                            if (fifo_full) begin
                                overflow    <= 1'b1;
                                capture_end <= 1'b1;
                                c_state     <= C_IDLE;
                            end else begin
                                words_pushed <= words_pushed + 22'd1;
                                if (words_pushed + 22'd1 == frame_words) begin
                                    capture_end <= 1'b1;
                                    c_state     <= C_IDLE;
                                end
                            end
                        end else begin
                            pack[{pack_idx, 4'b0000} +: 16] <= {2'b00, pix_data};
                            pack_idx <= pack_idx + 2'd1;
                        end
                    end
                end
                default: c_state <= C_IDLE;
            endcase

            case (w_state)
                W_IDLE: begin
                    if (busy) begin
                        if (fifo_count >= BURST_CNT || (capture_end && fifo_count != '0)) begin
                            len       <= issue_len;
                            m.awaddr  <= base + (AXI_AW'(words_sent) << 3);
                            m.awlen   <= 8'(issue_len) - 8'd1;
                            m.awvalid <= 1'b1;
                            w_state   <= W_AW;
                        end else if (capture_end) begin
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            capture_end <= 1'b0;
                        end
                    end
                end
                W_AW: begin
                    if (m.awready) begin
                        m.awvalid <= 1'b0;
                        m.wvalid  <= 1'b1;
                        m.wlast   <= (len == LW'(1));
                        beat      <= '0;
                        w_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (m.wready) begin
                        beat <= beat + LW'(1);
                        if (m.wlast) begin
                            m.wvalid <= 1'b0;
                            m.wlast  <= 1'b0;
                            m.bready <= 1'b1;
                            w_state  <= W_RESP;
                        end else begin
                            m.wlast <= (beat + LW'(2) == len);
                        end
                    end
                end
                W_RESP: begin
                    if (m.bvalid) begin
                        m.bready   <= 1'b0;
                        if (m.bresp != 2'b00) err <= 1'b1;
                        words_sent <= words_sent + 22'(len);
                        w_state    <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end
endmodule
